// File: rtl/satatrn_rxfisroute.sv
// SATA transport-layer receive FIS router.
// Splits the link-layer FIS word stream into two paths:
//   - register FISes go through a commit/rollback FIFO, so a consumer only
//     ever sees complete, error-free FISes;
//   - data FISes lose their header word and stream through a one-word
//     output register with back-pressure.
// Optional statistics counters are enabled by defining RXFISROUTE_STATS_EN;
// with the macro undefined the counters are tied to zero.
module satatrn_rxfisroute #(
  parameter int unsigned LGFIFO   = 5,
  parameter int unsigned MAXREGW  = 7,
  parameter logic [7:0]  FIS_DATA = 8'h46
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Link-layer input stream
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_last,
  output logic        o_ready,
  input  logic        i_err,
  // Committed register-FIS stream
  output logic        o_reg_valid,
  output logic [31:0] o_reg_data,
  output logic        o_reg_last,
  input  logic        i_reg_ready,
  // Data-FIS payload stream
  output logic        o_data_valid,
  output logic [31:0] o_data_data,
  output logic        o_data_last,
  input  logic        i_data_ready,
  // Event pulses
  output logic        o_data_abort,
  output logic        o_drop,
  // Statistics
  output logic [15:0] o_reg_count,
  output logic [15:0] o_data_count,
  output logic [15:0] o_drop_count
);

  localparam int unsigned Depth = 2 ** LGFIFO;
  localparam int unsigned CW    = $clog2(MAXREGW + 1) + 1;

  localparam logic [LGFIFO:0] PtrOne = {{LGFIFO{1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CntOne = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CntMax = CW'(MAXREGW);

  typedef enum logic [1:0] {StIdle, StReg, StData, StDrop} state_e;

  state_e state_q, state_d;

  // Pointers carry one extra bit to tell full from empty.
  logic [LGFIFO:0] wr_ptr_q, wr_ptr_d;
  logic [LGFIFO:0] cm_ptr_q, cm_ptr_d;
  logic [LGFIFO:0] rd_ptr_q, rd_eff;
  logic [CW-1:0]   reg_cnt_q, reg_cnt_d;

  logic [32:0] mem_q [Depth];

  logic        accept, rd_pop, fifo_full;
  logic        mem_we, data_ld, commit, data_end;
  logic        drop_d, drop_q, abort_d, abort_q;
  logic        dv_q, dv_d, dl_q, dl_d;
  logic [31:0] dd_q, dd_d;

  assign o_ready = (state_q == StData) ? (!dv_q || i_data_ready) : 1'b1;
  assign accept  = i_valid && o_ready;

  // Only committed words are visible to the register consumer.
  assign o_reg_valid              = (rd_ptr_q != cm_ptr_q);
  assign {o_reg_last, o_reg_data} = mem_q[rd_ptr_q[LGFIFO-1:0]];
  assign rd_pop                   = o_reg_valid && i_reg_ready;

  // A pop in this cycle frees its slot for a simultaneous write.
  assign rd_eff    = rd_ptr_q + (rd_pop ? PtrOne : '0);
  assign fifo_full = (wr_ptr_q[LGFIFO] != rd_eff[LGFIFO]) &&
                     (wr_ptr_q[LGFIFO-1:0] == rd_eff[LGFIFO-1:0]);

  assign o_data_valid = dv_q;
  assign o_data_data  = dd_q;
  assign o_data_last  = dl_q;
  assign o_drop       = drop_q;
  assign o_data_abort = abort_q;

  // Routing FSM: next state, FIFO pointer updates and event causes.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    reg_cnt_d = reg_cnt_q;
    mem_we    = 1'b0;
    data_ld   = 1'b0;
    commit    = 1'b0;
    data_end  = 1'b0;
    drop_d    = 1'b0;
    abort_d   = 1'b0;

    if (i_err) begin
      // Abort wins over any word presented in the same cycle.
      case (state_q)
        StReg: begin
          wr_ptr_d = cm_ptr_q;
          drop_d   = 1'b1;
        end
        StData:  abort_d = 1'b1;
        default: ;
      endcase
      state_d = StIdle;
    end else if (accept) begin
      case (state_q)
        StIdle: begin
          if (i_data[7:0] == FIS_DATA) begin
            // Data header is consumed here; payload follows.
            if (i_last) data_end = 1'b1;
            else        state_d  = StData;
          end else if (fifo_full) begin
            drop_d  = 1'b1;
            state_d = i_last ? StIdle : StDrop;
          end else begin
            mem_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PtrOne;
            reg_cnt_d = CntOne;
            if (i_last) begin
              cm_ptr_d = wr_ptr_q + PtrOne;
              commit   = 1'b1;
            end else begin
              state_d = StReg;
            end
          end
        end
        StReg: begin
          if (fifo_full || (reg_cnt_q >= CntMax)) begin
            wr_ptr_d = cm_ptr_q;
            drop_d   = 1'b1;
            state_d  = i_last ? StIdle : StDrop;
          end else begin
            mem_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PtrOne;
            reg_cnt_d = reg_cnt_q + CntOne;
            if (i_last) begin
              cm_ptr_d = wr_ptr_q + PtrOne;
              commit   = 1'b1;
              state_d  = StIdle;
            end
          end
        end
        StData: begin
          data_ld = 1'b1;
          if (i_last) begin
            data_end = 1'b1;
            state_d  = StIdle;
          end
        end
        StDrop: begin
          if (i_last) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Data output register: load on accept, otherwise drain on ready.
  always_comb begin
    dv_d = dv_q;
    dd_d = dd_q;
    dl_d = dl_q;
    if (data_ld) begin
      dv_d = 1'b1;
      dd_d = i_data;
      dl_d = i_last;
    end else if (i_data_ready) begin
      dv_d = 1'b0;
    end
  end

  // FIFO storage; contents are meaningless until committed, so no reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_ptr_q[LGFIFO-1:0]] <= {i_last, i_data};
  end

  // State, pointers, output register and event pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      reg_cnt_q <= '0;
      dv_q      <= 1'b0;
      dd_q      <= '0;
      dl_q      <= 1'b0;
      drop_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_eff;
      reg_cnt_q <= reg_cnt_d;
      dv_q      <= dv_d;
      dd_q      <= dd_d;
      dl_q      <= dl_d;
      drop_q    <= drop_d;
      abort_q   <= abort_d;
    end
  end

`ifdef RXFISROUTE_STATS_EN
  logic [15:0] reg_count_q, data_count_q, drop_count_q;

  // Saturating event counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      reg_count_q  <= '0;
      data_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (commit && (reg_count_q != 16'hFFFF))    reg_count_q  <= reg_count_q + 16'd1;
      if (data_end && (data_count_q != 16'hFFFF)) data_count_q <= data_count_q + 16'd1;
      if (drop_q && (drop_count_q != 16'hFFFF))   drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign o_reg_count  = reg_count_q;
  assign o_data_count = data_count_q;
  assign o_drop_count = drop_count_q;
`else
  logic unused_stats;
  assign unused_stats = ^{commit, data_end};

  assign o_reg_count  = 16'd0;
  assign o_data_count = 16'd0;
  assign o_drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_satatrn_rxfisroute.sv
// Self-checking bench for satatrn_rxfisroute: a table of FIS records plus
// hand-written sequences for back-pressure, abort, full-FIFO and reset.
module tb_satatrn_rxfisroute;

`ifdef RXFISROUTE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_valid, drv_last, drv_err;
  logic [31:0] drv_data;
  logic        reg_ready, data_ready, sel_small;

  logic        m_ready, m_reg_valid, m_reg_last, m_data_valid, m_data_last;
  logic        m_data_abort, m_drop;
  logic [31:0] m_reg_data, m_data_data;
  logic [15:0] m_reg_count, m_data_count, m_drop_count;

  logic        s_ready, s_reg_valid, s_reg_last, s_data_valid, s_data_last;
  logic        s_data_abort, s_drop;
  logic [31:0] s_reg_data, s_data_data;
  logic [15:0] s_reg_count, s_data_count, s_drop_count;

  always #5 clk = ~clk;

  satatrn_rxfisroute u_dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_valid      (drv_valid && !sel_small),
    .i_data       (drv_data),
    .i_last       (drv_last),
    .o_ready      (m_ready),
    .i_err        (drv_err && !sel_small),
    .o_reg_valid  (m_reg_valid),
    .o_reg_data   (m_reg_data),
    .o_reg_last   (m_reg_last),
    .i_reg_ready  (reg_ready),
    .o_data_valid (m_data_valid),
    .o_data_data  (m_data_data),
    .o_data_last  (m_data_last),
    .i_data_ready (data_ready),
    .o_data_abort (m_data_abort),
    .o_drop       (m_drop),
    .o_reg_count  (m_reg_count),
    .o_data_count (m_data_count),
    .o_drop_count (m_drop_count)
  );

  satatrn_rxfisroute #(.LGFIFO(2)) u_small (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_valid      (drv_valid && sel_small),
    .i_data       (drv_data),
    .i_last       (drv_last),
    .o_ready      (s_ready),
    .i_err        (drv_err && sel_small),
    .o_reg_valid  (s_reg_valid),
    .o_reg_data   (s_reg_data),
    .o_reg_last   (s_reg_last),
    .i_reg_ready  (reg_ready),
    .o_data_valid (s_data_valid),
    .o_data_data  (s_data_data),
    .o_data_last  (s_data_last),
    .i_data_ready (data_ready),
    .o_data_abort (s_data_abort),
    .o_drop       (s_drop),
    .o_reg_count  (s_reg_count),
    .o_data_count (s_data_count),
    .o_drop_count (s_drop_count)
  );

  typedef struct {
    logic [7:0] ftype;
    int         nwords;
    int         err_at;   // word index carrying i_err, -1 for none
    bit         commit;   // expected to appear on the register stream
    int         drop;     // expected o_drop pulses
    int         abort;    // expected o_data_abort pulses
  } vec_t;

  vec_t        tbl [9];
  logic [32:0] rg_q[$], sm_q[$], dt_q[$];
  int          checks = 0, passes = 0;
  int          m_drops = 0, m_aborts = 0, s_drops = 0;
  int          exp_reg = 0, exp_data = 0, exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [32:0] word);
    checks++;
    $display("FAIL %s: got word 0x%0h, required no output", name, word);
  endtask

  // Present one word; returns at posedge+1 after it is taken.
  task automatic drive_word(input logic [31:0] d, input bit last, input bit err);
    bit done = 1'b0;
    bit r;
    int n = 0;
    drv_valid = 1'b1;
    drv_data  = d;
    drv_last  = last;
    drv_err   = err;
    while (!done) begin
      @(negedge clk);
      r = sel_small ? s_ready : m_ready;
      @(posedge clk);
      n++;
      if (r || err) done = 1'b1;
      else if (n > 100) begin
        checks++;
        $display("FAIL accept_timeout: got no accept after %0d cycles, required accept", n);
        done = 1'b1;
      end
    end
    #1;
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    drv_err   = 1'b0;
  endtask

  task automatic send_fis(input logic [7:0] ftype, input int n, input int err_at,
                          input bit commit);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (i == 0) w[7:0] = ftype;
      if (i == err_at) begin
        drive_word(w, 1'b0, 1'b1);
        break;
      end
      if (ftype == 8'h46) begin
        if (i > 0) dt_q.push_back({(i == n - 1), w});
      end else if (commit) begin
        if (sel_small) sm_q.push_back({(i == n - 1), w});
        else           rg_q.push_back({(i == n - 1), w});
      end
      drive_word(w, (i == n - 1), 1'b0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (((rg_q.size() + sm_q.size() + dt_q.size()) != 0) && (n < 80)) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_reg_q", rg_q.size(), 0);
    check("drain_small_q", sm_q.size(), 0);
    check("drain_data_q", dt_q.size(), 0);
  endtask

  initial begin
    int d0, a0, s0;
    logic [31:0] w;

    tbl[0] = '{8'h34, 5, -1, 1'b1, 0, 0};  // plain 5-word register FIS
    tbl[1] = '{8'h27, 1, -1, 1'b1, 0, 0};  // single-word FIS
    tbl[2] = '{8'h5F, 8, -1, 1'b0, 1, 0};  // one word over MAXREGW
    tbl[3] = '{8'h34, 7, -1, 1'b1, 0, 0};  // exactly MAXREGW
    tbl[4] = '{8'h46, 5, -1, 1'b0, 0, 0};  // data FIS, 4 payload words
    tbl[5] = '{8'h46, 1, -1, 1'b0, 0, 0};  // header-only data FIS
    tbl[6] = '{8'h39, 4,  2, 1'b0, 1, 0};  // error on word 3 of register FIS
    tbl[7] = '{8'h46, 4,  2, 1'b0, 0, 1};  // error mid data FIS
    tbl[8] = '{8'hA1, 2,  0, 1'b0, 0, 0};  // error on header in idle

    rst        = 1'b1;
    drv_valid  = 1'b0;
    drv_last   = 1'b0;
    drv_err    = 1'b0;
    drv_data   = '0;
    reg_ready  = 1'b1;
    data_ready = 1'b1;
    sel_small  = 1'b0;

    // Output monitor / scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (m_reg_valid === 1'b1 && reg_ready) begin
          if (rg_q.size() == 0) unexpected("main_reg_unexpected", {m_reg_last, m_reg_data});
          else check("main_reg_word", {m_reg_last, m_reg_data}, rg_q.pop_front());
        end
        if (s_reg_valid === 1'b1 && reg_ready) begin
          if (sm_q.size() == 0) unexpected("small_reg_unexpected", {s_reg_last, s_reg_data});
          else check("small_reg_word", {s_reg_last, s_reg_data}, sm_q.pop_front());
        end
        if (m_data_valid === 1'b1 && data_ready) begin
          if (dt_q.size() == 0) unexpected("data_unexpected", {m_data_last, m_data_data});
          else check("data_word", {m_data_last, m_data_data}, dt_q.pop_front());
        end
        if (s_data_valid === 1'b1 || s_data_abort === 1'b1)
          unexpected("small_data_unexpected", {s_data_last, s_data_data});
        if (m_drop === 1'b1)       m_drops++;
        if (m_data_abort === 1'b1) m_aborts++;
        if (s_drop === 1'b1)       s_drops++;
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_reg_valid", m_reg_valid, 0);
    check("rst_data_valid", m_data_valid, 0);
    check("rst_drop", m_drop, 0);
    check("rst_abort", m_data_abort, 0);
    check("rst_ready", m_ready, 1);
    check("rst_reg_count", m_reg_count, 0);
    check("rst_data_count", m_data_count, 0);
    check("rst_drop_count", m_drop_count, 0);
    check("rst_small_reg_valid", s_reg_valid, 0);
    @(posedge clk);
    #1;

    // Table-driven FIS records.
    for (int i = 0; i < 9; i++) begin
      d0 = m_drops;
      a0 = m_aborts;
      send_fis(tbl[i].ftype, tbl[i].nwords, tbl[i].err_at, tbl[i].commit);
      drain();
      check($sformatf("v%0d_drop_pulses", i), m_drops - d0, tbl[i].drop);
      check($sformatf("v%0d_abort_pulses", i), m_aborts - a0, tbl[i].abort);
      if (tbl[i].commit) exp_reg++;
      if (tbl[i].ftype == 8'h46 && tbl[i].err_at < 0) exp_data++;
      exp_drop += tbl[i].drop;
    end
    check("reg_count", m_reg_count, StatsEn ? exp_reg : 0);
    check("data_count", m_data_count, StatsEn ? exp_data : 0);
    check("drop_count", m_drop_count, StatsEn ? exp_drop : 0);

    // Data FIS with the consumer stalled for three cycles mid-packet.
    w = $urandom;
    w[7:0] = 8'h46;
    drive_word(w, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      dt_q.push_back({1'b0, w});
      drive_word(w, 1'b0, 1'b0);
    end
    data_ready = 1'b0;
    fork
      begin
        logic [31:0] p3, p4;
        p3 = $urandom;
        p4 = $urandom;
        dt_q.push_back({1'b0, p3});
        dt_q.push_back({1'b1, p4});
        drive_word(p3, 1'b0, 1'b0);
        drive_word(p4, 1'b1, 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_ready_low", m_ready, 0);
        end
        @(posedge clk);
        #1 data_ready = 1'b1;
      end
    join
    drain();

    // Abort in DATA while a word sits in the output register.
    a0 = m_aborts;
    data_ready = 1'b0;
    w = $urandom;
    w[7:0] = 8'h46;
    drive_word(w, 1'b0, 1'b0);
    w = $urandom;
    dt_q.push_back({1'b0, w});
    drive_word(w, 1'b0, 1'b0);
    drive_word($urandom, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("held_abort_pulse", m_aborts - a0, 1);
    check("held_word_valid", m_data_valid, 1);
    check("held_word_pending", dt_q.size(), 1);
    data_ready = 1'b1;
    drain();

    // Small FIFO: fill, drop on full, release; then an exact-fit FIS.
    sel_small = 1'b1;
    reg_ready = 1'b0;
    s0 = s_drops;
    send_fis(8'h34, 3, -1, 1'b1);
    send_fis(8'h35, 2, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("small_full_drop", s_drops - s0, 1);
    check("small_reg_valid", s_reg_valid, 1);
    check("small_held_words", sm_q.size(), 3);
    reg_ready = 1'b1;
    drain();
    reg_ready = 1'b0;
    send_fis(8'h36, 4, -1, 1'b1);
    send_fis(8'h37, 1, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("small_idle_full_drop", s_drops - s0, 2);
    check("small_exact_fit_words", sm_q.size(), 4);
    reg_ready = 1'b1;
    drain();
    sel_small = 1'b0;
    check("small_reg_count", s_reg_count, StatsEn ? 2 : 0);
    check("small_drop_count", s_drop_count, StatsEn ? 2 : 0);
    check("small_data_count", s_data_count, 0);

    // Reset mid-REG with one committed FIS queued.
    reg_ready = 1'b0;
    send_fis(8'h34, 2, -1, 1'b0);
    w = $urandom;
    w[7:0] = 8'h34;
    drive_word(w, 1'b0, 1'b0);
    drive_word($urandom, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_reg_valid", m_reg_valid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_reg_valid", m_reg_valid, 0);
    check("post_reset_reg_count", m_reg_count, 0);
    @(posedge clk);
    #1;
    reg_ready = 1'b1;
    send_fis(8'h34, 3, -1, 1'b1);
    drain();
    check("post_reset_reg_count_after", m_reg_count, StatsEn ? 1 : 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
